mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 55 +++++
 rtl/mem_stage_load_formatter.sv | 29 ++
 rtl/mem_stage.sv | 149 ++++++++++++++
 tb/tb_mem_stage.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared encodings and helpers for the memory pipeline stage: write-back
// select codes, funct3 access codes, FSM state type and store lane helpers.
package mem_stage_pkg;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  // size is funct3[1:0]: 00 byte, 01 half, otherwise word
  function automatic logic access_aligned(input logic [1:0] size, input logic [1:0] offset);
    logic ok;
    case (size)
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~offset[0];
      default: ok = (offset == 2'b00);
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << offset;
      2'b01:   be = 4'b0011 << offset;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] wdata;
    case (size)
      2'b00:   wdata = {4{data[7:0]}};
      2'b01:   wdata = {2{data[15:0]}};
      default: wdata = data;
    endcase
    return wdata;
  endfunction

endpackage

// File: rtl/mem_stage_load_formatter.sv
// Selects the addressed byte/half/word from a read word and sign- or
// zero-extends it according to the load funct3.
module load_formatter
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  assign byte_s = rdata[{offset, 3'b000} +: 8];
  assign half_s = offset[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    result = rdata;
    case (funct3)
      F3_LB:   result = {{24{byte_s[7]}}, byte_s};
      F3_LBU:  result = {24'd0, byte_s};
      F3_LH:   result = {{16{half_s[15]}}, half_s};
      F3_LHU:  result = {16'd0, half_s};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues registered data-memory requests for aligned
// loads/stores, stalls upstream while one is in flight, and forms the WB bundle.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int AW          = 32,
  parameter bit NOLOAD_EXCP = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          MEM_useful,
  input  logic [31:0]   MEM_pc,
  input  logic [31:0]   MEM_from_alu,
  input  logic [4:0]    MEM_wR,
  input  logic [31:0]   MEM_data2,
  input  logic [6:0]    MEM_opcode,
  input  logic          MEM_regWEn,
  input  logic          MEM_memRW,
  input  logic [1:0]    MEM_wbSel,
  input  logic [2:0]    MEM_funct3,
  output logic          mem_stall,
  output logic          dm_req,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [3:0]    dm_be,
  output logic [31:0]   dm_wdata,
  input  logic          dm_ack,
  input  logic [31:0]   dm_rdata,
  output logic          WB_useful,
  output logic [31:0]   WB_pc,
  output logic [4:0]    WB_wR,
  output logic [31:0]   WB_wD,
  output logic          WB_regWEn,
  output logic          WB_excp
);

  logic [1:0]    offset;
  logic          is_access;
  logic          is_aligned;
  logic          mem_op;
  logic          misaligned;
  logic [AW-1:0] word_addr;
  state_t        state;
  state_t        state_nx;
  logic [31:0]   rdata_p1;
  logic [1:0]    offset_p1;
  logic [2:0]    funct3_p1;
  logic [31:0]   load_data;
  logic [31:0]   wd;
  logic          unused_opcode;

  assign offset     = MEM_from_alu[1:0];
  assign is_access  = MEM_useful & (MEM_memRW | (MEM_wbSel == WB_MEM));
  assign is_aligned = access_aligned(MEM_funct3[1:0], offset);
  assign mem_op     = is_access & is_aligned;
  assign misaligned = is_access & ~is_aligned;
  assign word_addr  = AW'(MEM_from_alu) & ~AW'(32'd3);
  assign unused_opcode = ^MEM_opcode;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // The RESP cycle is the only unstalled cycle of a memory op: the EX/MEM
  // register still holds the op, so the WB bundle is built from it then.
  always_comb begin
    state_nx  = state;
    mem_stall = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          mem_stall = 1'b1;
          state_nx  = REQ;
        end
      end
      REQ: begin
        mem_stall = 1'b1;
        if (dm_ack) state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (!rst) mem_stall = 1'b0;
  end

  load_formatter u_load_formatter (
    .rdata  (rdata_p1),
    .offset (offset_p1),
    .funct3 (funct3_p1),
    .result (load_data)
  );

  always_comb begin
    wd = MEM_from_alu;
    case (MEM_wbSel)
      WB_MEM:  wd = load_data;
      WB_PC4:  wd = MEM_pc + 32'd4;
      default: wd = MEM_from_alu;
    endcase
  end

  // Stage p1: request issue/capture and the write-back bundle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dm_req    <= 1'b0;
      dm_we     <= 1'b0;
      dm_addr   <= '0;
      dm_be     <= 4'b0000;
      dm_wdata  <= 32'd0;
      rdata_p1  <= 32'd0;
      offset_p1 <= 2'b00;
      funct3_p1 <= 3'b000;
      WB_useful <= 1'b0;
      WB_pc     <= 32'd0;
      WB_wR     <= 5'd0;
      WB_wD     <= 32'd0;
      WB_regWEn <= 1'b0;
      WB_excp   <= 1'b0;
    end else begin
      if (state == IDLE && mem_op) begin
        dm_req    <= 1'b1;
        dm_we     <= MEM_memRW;
        dm_addr   <= word_addr;
        dm_be     <= store_be(MEM_funct3[1:0], offset);
        dm_wdata  <= store_wdata(MEM_funct3[1:0], MEM_data2);
        offset_p1 <= offset;
        funct3_p1 <= MEM_funct3;
      end else if (state == REQ && dm_ack) begin
        dm_req   <= 1'b0;
        rdata_p1 <= dm_rdata;
      end

      if (mem_stall) begin
        WB_useful <= 1'b0;
        WB_regWEn <= 1'b0;
        WB_excp   <= 1'b0;
      end else begin
        WB_useful <= MEM_useful;
        WB_pc     <= MEM_pc;
        WB_wR     <= MEM_wR;
        WB_wD     <= wd;
        WB_regWEn <= MEM_regWEn & MEM_useful & ~misaligned;
        WB_excp   <= misaligned & NOLOAD_EXCP;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: reset values, a vector table of directed accesses,
// reset during an outstanding request, and randomized ops against a byte model.
`timescale 1ns/1ps
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MEM_useful, MEM_regWEn, MEM_memRW;
  logic [31:0] MEM_pc, MEM_from_alu, MEM_data2;
  logic [4:0]  MEM_wR;
  logic [6:0]  MEM_opcode;
  logic [1:0]  MEM_wbSel;
  logic [2:0]  MEM_funct3;
  logic        mem_stall, dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        WB_useful, WB_regWEn, WB_excp;
  logic [31:0] WB_pc, WB_wD;
  logic [4:0]  WB_wR;

  mem_stage #(.AW(32), .NOLOAD_EXCP(1'b1)) dut (
    .clk(clk), .rst(rst),
    .MEM_useful(MEM_useful), .MEM_pc(MEM_pc), .MEM_from_alu(MEM_from_alu),
    .MEM_wR(MEM_wR), .MEM_data2(MEM_data2), .MEM_opcode(MEM_opcode),
    .MEM_regWEn(MEM_regWEn), .MEM_memRW(MEM_memRW), .MEM_wbSel(MEM_wbSel),
    .MEM_funct3(MEM_funct3), .mem_stall(mem_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .WB_useful(WB_useful), .WB_pc(WB_pc), .WB_wR(WB_wR), .WB_wD(WB_wD),
    .WB_regWEn(WB_regWEn), .WB_excp(WB_excp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        useful;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [4:0]  wR;
    logic [31:0] data2;
    logic        memRW;
    logic        regWEn;
    logic [1:0]  wbSel;
    logic [2:0]  f3;
  } instr_t;

  typedef struct {
    logic [31:0] wd;
    logic        chk_wd;
    logic        regwen;
    logic        excp;
    int          stalls;
    logic        memop;
    logic        chk_dm;
    logic [3:0]  be;
    logic [31:0] wdata;
  } exp_t;

  typedef struct {
    instr_t in;
    int     d;
    exp_t   e;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sim_mem [64];
  logic [7:0]  ref_mem [256];
  vec_t        vt [16];

  function automatic instr_t mk(input logic u, input logic [31:0] pc, input logic [31:0] a,
                                input logic [4:0] wr, input logic [31:0] d2, input logic rw,
                                input logic we, input logic [1:0] sel, input logic [2:0] f3);
    instr_t r;
    r.useful = u; r.pc = pc; r.addr = a; r.wR = wr; r.data2 = d2;
    r.memRW = rw; r.regWEn = we; r.wbSel = sel; r.f3 = f3;
    return r;
  endfunction

  function automatic exp_t mke(input logic [31:0] wd, input logic cw, input logic rwe,
                               input logic ex, input int st, input logic mo, input logic cd,
                               input logic [3:0] be, input logic [31:0] wdata);
    exp_t r;
    r.wd = wd; r.chk_wd = cw; r.regwen = rwe; r.excp = ex; r.stalls = st;
    r.memop = mo; r.chk_dm = cd; r.be = be; r.wdata = wdata;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input instr_t in);
    MEM_useful   = in.useful;
    MEM_pc       = in.pc;
    MEM_from_alu = in.addr;
    MEM_wR       = in.wR;
    MEM_data2    = in.data2;
    MEM_regWEn   = in.regWEn;
    MEM_memRW    = in.memRW;
    MEM_wbSel    = in.wbSel;
    MEM_funct3   = in.f3;
    MEM_opcode   = in.memRW ? 7'h23 : (in.wbSel == WB_MEM ? 7'h03 :
                   (in.wbSel == WB_PC4 ? 7'h6f : 7'h33));
  endtask

  task automatic init_mem();
    logic [31:0] w;
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      sim_mem[i] = w;
      for (int b = 0; b < 4; b++) ref_mem[i*4+b] = w[8*b +: 8];
    end
  endtask

  // Byte-level reference: what an access does to memory and what WB must show.
  task automatic model(input instr_t in, input int d, output exp_t e);
    int          size;
    int          a;
    bit          acc;
    bit          mis;
    logic [31:0] v;
    size = (in.f3[1:0] == 2'b00) ? 1 : ((in.f3[1:0] == 2'b01) ? 2 : 4);
    acc  = in.useful && (in.memRW || in.wbSel == WB_MEM);
    a    = int'(in.addr[7:0]);
    mis  = acc && ((in.addr % size) != 0);
    e = mke(32'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 4'd0, 32'd0);
    e.memop  = acc && !mis;
    e.excp   = mis;
    e.regwen = in.regWEn && in.useful && !mis;
    e.stalls = e.memop ? 2 + d : 0;
    v = 32'd0;
    if (e.memop && in.memRW) begin
      for (int b = 0; b < size; b++) ref_mem[a+b] = in.data2[8*b +: 8];
    end else if (e.memop) begin
      for (int b = 0; b < size; b++) v = v | (32'(ref_mem[a+b]) << (8*b));
      if (!in.f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
    end
    case (in.wbSel)
      WB_MEM:  e.wd = v;
      WB_PC4:  e.wd = in.pc + 32'd4;
      default: e.wd = in.addr;
    endcase
    e.chk_wd = (in.wbSel != WB_MEM) || (e.memop && !in.memRW);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the op leaves the stage.
  task automatic run_instr(input string tag, input instr_t in, input int d, input exp_t e);
    int          cyc, stalls, reqs;
    bit          done, unstable, bubble;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_be;
    logic        s_we;
    drive(in);
    cyc = 0; stalls = 0; reqs = 0; done = 0; unstable = 0; bubble = 0;
    s_addr = 0; s_wdata = 0; s_be = 0; s_we = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc >= 2 && WB_useful) bubble = 1;
      if (dm_req) begin
        if (reqs == 0) begin
          s_addr = dm_addr; s_we = dm_we; s_be = dm_be; s_wdata = dm_wdata;
          chk({tag, ".dm_addr"}, dm_addr, in.addr & ~32'd3);
          chk({tag, ".dm_we"}, 32'(dm_we), 32'(in.memRW));
          if (e.chk_dm) begin
            chk({tag, ".dm_be"}, 32'(dm_be), 32'(e.be));
            chk({tag, ".dm_wdata"}, dm_wdata, e.wdata);
          end
        end else if (dm_addr !== s_addr || dm_we !== s_we || dm_be !== s_be ||
                     dm_wdata !== s_wdata) begin
          unstable = 1;
        end
        reqs++;
        if (reqs == d + 1) begin
          dm_ack   = 1'b1;
          dm_rdata = sim_mem[dm_addr[7:2]];
          if (dm_we)
            for (int i = 0; i < 4; i++)
              if (dm_be[i]) sim_mem[dm_addr[7:2]][8*i +: 8] = dm_wdata[8*i +: 8];
        end else begin
          dm_ack   = 1'b0;
          dm_rdata = $urandom;
        end
      end else begin
        dm_ack   = 1'($urandom_range(0, 1));
        dm_rdata = $urandom;
      end
      if (mem_stall) stalls++;
      else           done = 1;
      @(posedge clk);
      #1;
      dm_ack = 1'b0;
    end
    chk({tag, ".completed"}, 32'(done), 32'd1);
    chk({tag, ".stall_cycles"}, stalls, e.stalls);
    chk({tag, ".req_cycles"}, reqs, e.memop ? d + 1 : 0);
    chk({tag, ".dm_stable"}, 32'(unstable), 32'd0);
    chk({tag, ".bubbles"}, 32'(bubble), 32'd0);
    chk({tag, ".WB_useful"}, 32'(WB_useful), 32'(in.useful));
    chk({tag, ".WB_pc"}, WB_pc, in.pc);
    chk({tag, ".WB_wR"}, 32'(WB_wR), 32'(in.wR));
    chk({tag, ".WB_regWEn"}, 32'(WB_regWEn), 32'(e.regwen));
    chk({tag, ".WB_excp"}, 32'(WB_excp), 32'(e.excp));
    if (e.chk_wd) chk({tag, ".WB_wD"}, WB_wD, e.wd);
  endtask

  initial begin
    instr_t in;
    exp_t   e;
    int     d;
    int     kind;
    int     r;

    dm_ack = 1'b0;
    dm_rdata = 32'd0;
    init_mem();
    sim_mem[0] = 32'h80FF_0000;

    // Reset values, with a load presented so the stall gating is exercised
    drive(mk(1, 32'h10, 32'h104, 5'd2, 32'd0, 0, 1, WB_MEM, F3_LW));
    #3;
    chk("rst.mem_stall", 32'(mem_stall), 32'd0);
    chk("rst.dm_req", 32'(dm_req), 32'd0);
    chk("rst.dm_we", 32'(dm_we), 32'd0);
    chk("rst.dm_be", 32'(dm_be), 32'd0);
    chk("rst.dm_addr", dm_addr, 32'd0);
    chk("rst.dm_wdata", dm_wdata, 32'd0);
    chk("rst.WB_useful", 32'(WB_useful), 32'd0);
    chk("rst.WB_pc", WB_pc, 32'd0);
    chk("rst.WB_wR", 32'(WB_wR), 32'd0);
    chk("rst.WB_wD", WB_wD, 32'd0);
    chk("rst.WB_regWEn", 32'(WB_regWEn), 32'd0);
    chk("rst.WB_excp", 32'(WB_excp), 32'd0);
    drive(mk(0, 32'd0, 32'd0, 5'd0, 32'd0, 0, 0, WB_ALU, F3_LW));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    vt[0]  = '{mk(1, 32'h40, 32'h103, 5'd1, 32'd0, 0, 1, WB_MEM, F3_LB), 0,
               mke(32'hFFFF_FF80, 1, 1, 0, 2, 1, 0, 4'd0, 32'd0)};
    vt[1]  = '{mk(1, 32'h44, 32'h103, 5'd2, 32'd0, 0, 1, WB_MEM, F3_LBU), 1,
               mke(32'h0000_0080, 1, 1, 0, 3, 1, 0, 4'd0, 32'd0)};
    vt[2]  = '{mk(1, 32'h48, 32'h102, 5'd3, 32'd0, 0, 1, WB_MEM, F3_LHU), 0,
               mke(32'h0000_80FF, 1, 1, 0, 2, 1, 0, 4'd0, 32'd0)};
    vt[3]  = '{mk(1, 32'h4c, 32'h102, 5'd4, 32'h1234_BEEF, 1, 0, WB_ALU, F3_SH), 0,
               mke(32'h0000_0102, 1, 0, 0, 2, 1, 1, 4'b1100, 32'hBEEF_BEEF)};
    vt[4]  = '{mk(1, 32'h50, 32'h102, 5'd5, 32'd0, 0, 1, WB_MEM, F3_LH), 2,
               mke(32'hFFFF_BEEF, 1, 1, 0, 4, 1, 0, 4'd0, 32'd0)};
    vt[5]  = '{mk(1, 32'h54, 32'h100, 5'd6, 32'hDEAD_BEEF, 1, 0, WB_ALU, F3_SW), 0,
               mke(32'h0000_0100, 1, 0, 0, 2, 1, 1, 4'b1111, 32'hDEAD_BEEF)};
    vt[6]  = '{mk(1, 32'h58, 32'h100, 5'd7, 32'd0, 0, 1, WB_MEM, F3_LW), 4,
               mke(32'hDEAD_BEEF, 1, 1, 0, 6, 1, 0, 4'd0, 32'd0)};
    vt[7]  = '{mk(1, 32'h5c, 32'h101, 5'd8, 32'h0000_005A, 1, 0, WB_ALU, F3_SB), 0,
               mke(32'h0000_0101, 1, 0, 0, 2, 1, 1, 4'b0010, 32'h5A5A_5A5A)};
    vt[8]  = '{mk(1, 32'h60, 32'h100, 5'd9, 32'd0, 0, 1, WB_MEM, F3_LW), 0,
               mke(32'hDEAD_5AEF, 1, 1, 0, 2, 1, 0, 4'd0, 32'd0)};
    vt[9]  = '{mk(1, 32'h64, 32'h101, 5'd10, 32'd0, 0, 1, WB_MEM, F3_LH), 0,
               mke(32'd0, 0, 0, 1, 0, 0, 0, 4'd0, 32'd0)};
    vt[10] = '{mk(1, 32'h68, 32'h102, 5'd11, 32'h1, 1, 0, WB_ALU, F3_SW), 0,
               mke(32'h0000_0102, 1, 0, 1, 0, 0, 0, 4'd0, 32'd0)};
    vt[11] = '{mk(0, 32'h6c, 32'h100, 5'd12, 32'd0, 0, 1, WB_MEM, F3_LW), 0,
               mke(32'd0, 0, 0, 0, 0, 0, 0, 4'd0, 32'd0)};
    vt[12] = '{mk(1, 32'h70, 32'h1234, 5'd13, 32'd0, 0, 1, WB_ALU, F3_LW), 0,
               mke(32'h0000_1234, 1, 1, 0, 0, 0, 0, 4'd0, 32'd0)};
    vt[13] = '{mk(1, 32'h200, 32'h77, 5'd1, 32'd0, 0, 1, WB_PC4, F3_LW), 0,
               mke(32'h0000_0204, 1, 1, 0, 0, 0, 0, 4'd0, 32'd0)};
    vt[14] = '{mk(1, 32'h74, 32'h55, 5'd0, 32'd0, 0, 1, WB_ALU, F3_LW), 0,
               mke(32'h0000_0055, 1, 1, 0, 0, 0, 0, 4'd0, 32'd0)};
    vt[15] = '{mk(1, 32'hFFFF_FFFC, 32'h9, 5'd31, 32'd0, 0, 1, WB_PC4, F3_LW), 0,
               mke(32'h0000_0000, 1, 1, 0, 0, 0, 0, 4'd0, 32'd0)};

    for (int k = 0; k < 16; k++) run_instr($sformatf("vec%0d", k), vt[k].in, vt[k].d, vt[k].e);

    // Reset while a load waits for its ack: access abandoned, next store runs cleanly
    init_mem();
    drive(mk(1, 32'h300, 32'h104, 5'd3, 32'd0, 0, 1, WB_MEM, F3_LW));
    @(posedge clk); #1;
    chk("rstreq.dm_req_before", 32'(dm_req), 32'd1);
    @(posedge clk); #1;
    #2 rst = 1'b0;
    #1;
    chk("rstreq.dm_req", 32'(dm_req), 32'd0);
    chk("rstreq.mem_stall", 32'(mem_stall), 32'd0);
    chk("rstreq.WB_useful", 32'(WB_useful), 32'd0);
    chk("rstreq.WB_regWEn", 32'(WB_regWEn), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    in = mk(1, 32'h310, 32'h105, 5'd4, 32'h0000_00A5, 1, 0, WB_ALU, F3_SB);
    model(in, 1, e);
    run_instr("rstreq.sb", in, 1, e);
    in = mk(1, 32'h314, 32'h105, 5'd5, 32'd0, 0, 1, WB_MEM, F3_LBU);
    model(in, 0, e);
    run_instr("rstreq.lbu", in, 0, e);
    chk("rstreq.lbu_value", WB_wD, 32'h0000_00A5);

    // Randomized mix against the byte-level model
    for (int k = 0; k < 300; k++) begin
      kind = $urandom_range(0, 4);
      in = mk(1, $urandom & ~32'd3, $urandom, 5'($urandom), $urandom, 0,
              1'($urandom), WB_ALU, F3_LW);
      case (kind)
        1: in.wbSel = WB_PC4;
        2, 4: begin
          in.wbSel = WB_MEM;
          in.addr  = 32'h100 + 32'($urandom_range(0, 255));
          r = $urandom_range(0, 4);
          in.f3 = (r < 3) ? 3'(r) : 3'(r + 1);
          if (kind == 4) in.useful = 1'b0;
        end
        3: begin
          in.memRW  = 1'b1;
          in.regWEn = 1'b0;
          in.addr   = 32'h100 + 32'($urandom_range(0, 255));
          in.f3     = 3'($urandom_range(0, 2));
        end
        default: ;
      endcase
      d = $urandom_range(0, 3);
      model(in, d, e);
      run_instr($sformatf("rnd%0d", k), in, d, e);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
